// File: rtl/ex_ctrl_pkg.sv
// ex_ctrl_pkg: shared op-class and FSM state types for the EX stage controller.
package ex_ctrl_pkg;
    typedef enum logic [1:0] {
        OP_SINGLE = 2'd0,
        OP_MUL    = 2'd1,
        OP_DIV    = 2'd2,
        OP_RSVD   = 2'd3
    } op_class_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ex_ctrl_state_t;
endpackage

// File: rtl/ex_stage_controller_counter.sv
// ex_latency_counter: loadable down-counter with clear and zero flag.
module ex_latency_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic         clr,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec) cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/ex_stage_controller.sv
// ex_stage_controller: EX-stage sequencer for multi-cycle MUL/DIV ops.
// Optional stall counter enabled by defining EX_CTRL_PERF_COUNT_EN.
module ex_stage_controller
    import ex_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_EX,
    input  logic [1:0]  op_class_EX,
    input  logic        flush,
    input  logic        mem_stall,
    output logic        stall_upstream,
    output logic        invalid_EX,
    output logic        unit_start,
    output logic        unit_step,
    output logic        unit_abort,
    output logic        result_sel,
    output logic        busy,
    output logic [31:0] stall_cycles
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    ex_ctrl_state_t state, next;
    logic [CW-1:0] cnt;
    logic zero, ld, dec, clr;
    logic start, step, abort, rsel, inv, stall;

    ex_latency_counter #(.W(CW)) u_cnt (
        .clk(clk),
        .rst_n(rst_n),
        .load(ld),
        .dec(dec),
        .clr(clr),
        .load_val(op_class_EX == OP_DIV ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1)),
        .cnt(cnt),
        .zero(zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next;
    end

    // flush outranks every other condition once a unit op is in flight
    always_comb begin
        next = state;
        start = 1'b0;
        step = 1'b0;
        abort = 1'b0;
        rsel = 1'b0;
        inv = 1'b1;
        stall = 1'b0;
        ld = 1'b0;
        dec = 1'b0;
        clr = 1'b0;
        case (state)
            IDLE: begin
                start = valid_EX & !flush & (op_class_EX == OP_MUL || op_class_EX == OP_DIV);
                inv = start | !valid_EX | flush;
                stall = start | (mem_stall & !flush);
                ld = start;
                next = start ? BUSY : IDLE;
            end
            BUSY: begin
                abort = flush;
                clr = flush;
                step = !flush;
                stall = !flush;
                dec = !flush & !zero;
                next = flush ? IDLE : (zero ? DONE : BUSY);
            end
            DONE: begin
                abort = flush;
                clr = flush;
                rsel = !flush;
                inv = flush;
                stall = !flush & mem_stall;
                next = (flush || !mem_stall) ? IDLE : DONE;
            end
            default: next = IDLE;
        endcase
    end

    assign invalid_EX = !rst_n | inv;
    assign stall_upstream = rst_n & stall;
    assign unit_start = rst_n & start;
    assign unit_step = rst_n & step;
    assign unit_abort = rst_n & abort;
    assign result_sel = rst_n & rsel;
    assign busy = rst_n & (state != IDLE);

`ifdef EX_CTRL_PERF_COUNT_EN
    logic [31:0] perf;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf <= '0;
        else if (stall_upstream && perf != 32'hFFFF_FFFF) perf <= perf + 1'b1;
    end
    assign stall_cycles = perf;
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_ex_stage_controller.sv
// tb_ex_stage_controller: directed + random checks against an age-based behavioural model.
module tb_ex_stage_controller;
    import ex_ctrl_pkg::*;

    localparam int MULC = 4;
    localparam int DIVC = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_EX = 1'b0;
    logic [1:0] op_class_EX = 2'd0;
    logic flush = 1'b0;
    logic mem_stall = 1'b0;
    logic stall_upstream, invalid_EX, unit_start, unit_step, unit_abort, result_sel, busy;
    logic [31:0] stall_cycles;

    int errors = 0;
    int checks = 0;
    int stall_seen = 0;
    int rsel_seen = 0;
    bit m_active = 0;
    int m_age = 0;
    int m_lat = 0;
    longint m_perf = 0;

    ex_stage_controller #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .valid_EX(valid_EX),
        .op_class_EX(op_class_EX),
        .flush(flush),
        .mem_stall(mem_stall),
        .stall_upstream(stall_upstream),
        .invalid_EX(invalid_EX),
        .unit_start(unit_start),
        .unit_step(unit_step),
        .unit_abort(unit_abort),
        .result_sel(result_sel),
        .busy(busy),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // The model tracks an op by its age since start: ages 1..lat are iterations, beyond is result-ready.
    task automatic cyc(input logic v, input logic [1:0] op, input logic f, input logic ms);
        logic e_start, e_step, e_abort, e_rs, e_inv, e_stall;
        valid_EX = v;
        op_class_EX = op;
        flush = f;
        mem_stall = ms;
        e_start = 0; e_step = 0; e_abort = 0; e_rs = 0; e_inv = 1; e_stall = 0;
        #1;
        if (!m_active) begin
            e_start = v && !f && (op == OP_MUL || op == OP_DIV);
            e_inv = e_start || !v || f;
            e_stall = e_start || (ms && !f);
        end else if (f) begin
            e_abort = 1;
        end else if (m_age <= m_lat) begin
            e_step = 1;
            e_stall = 1;
        end else begin
            e_rs = 1;
            e_inv = 0;
            e_stall = ms;
        end
        chk("invalid_EX", invalid_EX, e_inv);
        chk("stall_upstream", stall_upstream, e_stall);
        chk("unit_start", unit_start, e_start);
        chk("unit_step", unit_step, e_step);
        chk("unit_abort", unit_abort, e_abort);
        chk("result_sel", result_sel, e_rs);
        chk("busy", busy, m_active);
        chk("stall_cycles", stall_cycles, m_perf[31:0]);
        stall_seen += int'(stall_upstream);
        rsel_seen += int'(result_sel);
        @(posedge clk);
`ifdef EX_CTRL_PERF_COUNT_EN
        if (e_stall && m_perf < 64'hFFFF_FFFF) m_perf++;
`endif
        if (!m_active) begin
            if (e_start) begin
                m_active = 1;
                m_age = 1;
                m_lat = (op == OP_DIV) ? DIVC : MULC;
            end
        end else if (f) m_active = 0;
        else if (m_age <= m_lat) m_age++;
        else if (!ms) m_active = 0;
        @(negedge clk);
    endtask

    initial begin
        int p0;
        #12;
        rst_n = 1'b1;
        @(negedge clk);
        cyc(1, OP_SINGLE, 0, 0);
        chk("reset_single_inv", invalid_EX, 0);
        // MUL with no backpressure: 5 stall cycles, one result cycle
        stall_seen = 0; rsel_seen = 0;
        cyc(1, OP_MUL, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, OP_SINGLE, 0, 0);
        cyc(0, OP_SINGLE, 0, 0);
        chk("mul_stall_len", stall_seen, 1 + MULC);
        chk("mul_result_cycles", rsel_seen, 1);
        // DIV with 3 cycles of backpressure during DONE
        rsel_seen = 0;
        cyc(1, OP_DIV, 0, 0);
        for (int i = 0; i < DIVC; i++) cyc(1, OP_DIV, 0, i[0]);
        for (int i = 0; i < 3; i++) cyc(0, OP_SINGLE, 0, 1);
        cyc(0, OP_SINGLE, 0, 0);
        chk("div_done_len", rsel_seen, 4);
        chk("div_idle_after", busy, 0);
        // flush in the 2nd BUSY cycle of a DIV
        rsel_seen = 0;
        cyc(1, OP_DIV, 0, 0);
        cyc(0, OP_SINGLE, 0, 0);
        cyc(0, OP_SINGLE, 1, 1);
        cyc(0, OP_SINGLE, 0, 0);
        chk("flush_no_result", rsel_seen, 0);
        // flush coincident with a start request in IDLE
        cyc(1, OP_DIV, 1, 0);
        cyc(0, OP_SINGLE, 0, 0);
        // two back-to-back MULs
        p0 = int'(stall_cycles);
        cyc(1, OP_MUL, 0, 0);
        for (int i = 0; i < MULC; i++) cyc(1, OP_MUL, 0, 0);
        cyc(1, OP_MUL, 0, 0);
        cyc(1, OP_MUL, 0, 0);
        for (int i = 0; i < MULC; i++) cyc(0, OP_SINGLE, 0, 0);
        cyc(0, OP_SINGLE, 0, 0);
`ifdef EX_CTRL_PERF_COUNT_EN
        chk("perf_two_mul", stall_cycles - p0, 2 * (1 + MULC));
`else
        chk("perf_tied_zero", stall_cycles, 0);
`endif
        // asynchronous reset mid-BUSY
        cyc(1, OP_DIV, 0, 0);
        cyc(0, OP_SINGLE, 0, 0);
        valid_EX = 1; op_class_EX = OP_SINGLE; flush = 0; mem_stall = 1;
        rst_n = 1'b0;
        #1;
        chk("rst_invalid", invalid_EX, 1);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall_upstream, 0);
        chk("rst_step", unit_step, 0);
        chk("rst_cycles", stall_cycles, 0);
        m_active = 0; m_perf = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, OP_SINGLE, 0, 0);
        chk("post_rst_stall", stall_upstream, 0);
        // random traffic
        for (int i = 0; i < 3000; i++)
            cyc(1'($urandom), 2'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
